iot_event_scheduler: RTL and testbench
======================================

# iot_event_scheduler

Front-end controller for the active-IoT-devices monitor counter. Collects asynchronous-in-time on/off events from `N_DEV` device ports, holds one pending event per device, and serialises them by round-robin arbitration into single-cycle `change`/`on_off` pulses driving the monitor's counter inputs. Maintains a per-device active bitmap so that the monitor count stays consistent with real device state.

## Interface
- `N_DEV`, 4: number of device ports; 2..255, so the 8-bit monitor count cannot overflow.
- `ID_W`, `$clog2(N_DEV)`: width of `grant_id`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in N_DEV: per-device event strobe, sampled each rising edge.
- `req_on` in N_DEV: event direction per device (1 = device turned on, 0 = turned off); valid only where `req` is set.
- `change` out 1: one-cycle pulse to the monitor; at most one per cycle.
- `on_off` out 1: direction accompanying `change`; holds its last value otherwise.
- `grant_id` out ID_W: device index of the current/last forwarded event.
- `active_map` out N_DEV: registered bitmap of devices currently on.
- `busy` out 1: high while any event is pending (OR of pending bits).
- `drop` out 1: one-cycle pulse when a redundant event is discarded (exists only with `SCHED_FILTER_EN`; tied 0 otherwise).

## Operation
- Per device: `pend[i]` and `pdir[i]` registers. `req[i]` at an edge sets `pend[i]`=1 and `pdir[i]`=`req_on[i]`.
- A new request for a device that already has a pending event overwrites its direction (last wins); no queueing beyond depth 1.
- Arbiter: round-robin over `pend`, search starting at pointer `ptr`. Grant index g = first set bit at or after `ptr` (wrapping).
- On grant at an edge: `pend[g]` cleared; `ptr` <= (g+1) mod N_DEV; `grant_id` <= g; `active_map[g]` <= `pdir[g]`.
- Forwarded event: `change` <= 1, `on_off` <= `pdir[g]`. No pending bit: `change` <= 0, `ptr` unchanged.
- Simultaneous `req[g]` and grant of g at the same edge: set wins; `pend[g]` stays 1 with the new direction, and the old event is still forwarded.
- Requests on non-granted devices are captured in parallel; none are lost.
- `busy` is combinational from `pend` registers only.
- Reset (any time, including mid-burst): `pend`=0, `pdir`=0, `ptr`=0, `change`=0, `on_off`=0, `grant_id`=0, `active_map`=0, `drop`=0. Pending events are discarded. The monitor is reset by the same `rst`.

## Timing
- `req[i]` high before edge k -> `pend[i]` high after k -> earliest `change` high in the cycle after edge k+1 (one-cycle latency from capture).
- Throughput: one granted event per cycle; with all N_DEV pending, all are serviced in N_DEV consecutive cycles.
- Worst-case wait for a device once pending: N_DEV cycles.
- `change`, `on_off`, `grant_id`, `drop`, and `active_map` are all registered and update on the same edge.

## Configuration
- `SCHED_FILTER_EN` defined: at grant, if `pdir[g]` equals `active_map[g]` (on for an already-active device, or off for an inactive device), the event is consumed. `pend[g]` is cleared, `ptr` advances, and `grant_id` updates, but `change` stays 0 and `drop` pulses 1. The monitor count always equals popcount(`active_map`).
- `SCHED_FILTER_EN` undefined: every granted event is forwarded as `change`, redundant or not. `active_map` is still updated, and `drop` is constant 0.

## Structure
- Shared package `iot_pkg`: default `N_DEV`, `ID_W` function/constant, and the direction constants `DEV_ON`=1 and `DEV_OFF`=0.
- One sub-module, `rr_arbiter`: a parameterised combinational round-robin grant from a request vector and pointer, producing a one-hot grant, an index, and a valid flag. The pointer register lives in the parent.

## Test plan
- Reset: assert `rst` mid-cycle with 3 pending -> all outputs 0 immediately, `busy`=0, and no `change` after release.
- Single event: `req`=4'b0010, `req_on`=4'b0010 for one cycle -> exactly one `change` pulse, with `on_off`=1, `grant_id`=1, and `active_map`=4'b0010, starting 2 edges after the request.
- Burst fairness: `req`=4'b1111, all on, in one cycle -> `change` for 4 consecutive cycles, `grant_id` sequence 0,1,2,3, final `active_map`=4'b1111, and monitor count 4.
- Overwrite and collision: `req[2]` on, then `req[2]` off the next cycle while device 0 is being granted -> a single event for device 2 with `on_off`=0. Then `req[0]` again at the same edge as its grant -> a second event for device 0 follows.
- Filter (with `SCHED_FILTER_EN`): turn device 3 on twice -> one `change` and one `drop`, with the count at 1. Without the macro, the same stimulus gives two `change` pulses and a count of 2.
- Wrap-around: `ptr`=3 with `pend`=4'b1001 -> grant 3 then 0; `ptr` ends at 1.

Source files
------------

// File: rtl/iot_pkg.sv
// rtl/iot_pkg.sv - shared constants and helpers for the IoT event scheduler
package iot_pkg;

   localparam int   N_DEV_DEF = 4;
   localparam logic DEV_ON    = 1'b1;
   localparam logic DEV_OFF   = 1'b0;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at a pointer
// The pointer register is owned by the parent.
module rr_arbiter
   import iot_pkg::*;
#(
   parameter int N  = N_DEV_DEF,
   parameter int IW = id_width(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt_oh,
   output logic [IW-1:0] o_gnt_idx,
   output logic          o_gnt_valid
);

   always_comb begin
      int w_j;
      w_j         = 0;
      o_gnt_oh    = '0;
      o_gnt_idx   = '0;
      o_gnt_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= N) w_j = w_j - N;
         if (!o_gnt_valid && i_req[w_j]) begin
            o_gnt_valid   = 1'b1;
            o_gnt_idx     = IW'(w_j);
            o_gnt_oh[w_j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/iot_event_scheduler.sv
// rtl/iot_event_scheduler.sv - serialises per-device on/off events into monitor pulses
// SCHED_FILTER_EN: discard events that would not change a device's active state.
module iot_event_scheduler
   import iot_pkg::*;
#(
   parameter int N_DEV = N_DEV_DEF,
   parameter int ID_W  = id_width(N_DEV)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_DEV-1:0] req,
   input  logic [N_DEV-1:0] req_on,
   output logic             change,
   output logic             on_off,
   output logic [ID_W-1:0]  grant_id,
   output logic [N_DEV-1:0] active_map,
   output logic             busy,
   output logic             drop
);

   logic [N_DEV-1:0] r_pend;
   logic [N_DEV-1:0] r_pdir;
   logic [ID_W-1:0]  r_ptr;
   logic             r_change;
   logic             r_on_off;
   logic [ID_W-1:0]  r_grant_id;
   logic [N_DEV-1:0] r_active_map;

   logic [N_DEV-1:0] w_gnt_oh;
   logic [ID_W-1:0]  w_gnt_idx;
   logic             w_gnt_valid;
   logic             w_gnt_dir;
   logic             w_fwd;
   logic [ID_W-1:0]  w_ptr_next;

   rr_arbiter #(
      .N  (N_DEV),
      .IW (ID_W)
   ) u_arb (
      .i_req       (r_pend),
      .i_ptr       (r_ptr),
      .o_gnt_oh    (w_gnt_oh),
      .o_gnt_idx   (w_gnt_idx),
      .o_gnt_valid (w_gnt_valid)
   );

   assign w_gnt_dir  = r_pdir[w_gnt_idx];
   assign w_ptr_next = (w_gnt_idx == ID_W'(N_DEV - 1)) ? '0 : w_gnt_idx + ID_W'(1);

`ifdef SCHED_FILTER_EN
   logic w_redundant;
   logic r_drop;

   assign w_redundant = (w_gnt_dir == r_active_map[w_gnt_idx]);
   assign w_fwd       = w_gnt_valid & ~w_redundant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_drop <= 1'b0;
      else     r_drop <= w_gnt_valid & w_redundant;
   end

   assign drop = r_drop;
`else
   assign w_fwd = w_gnt_valid;
   assign drop  = 1'b0;
`endif

   // A request landing on the granted device re-arms it: set beats clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend       <= '0;
         r_pdir       <= '0;
         r_ptr        <= '0;
         r_change     <= 1'b0;
         r_on_off     <= DEV_OFF;
         r_grant_id   <= '0;
         r_active_map <= '0;
      end else begin
         r_pend   <= (r_pend & ~w_gnt_oh) | req;
         r_pdir   <= (r_pdir & ~req) | (req_on & req);
         r_change <= w_fwd;
         if (w_fwd) r_on_off <= w_gnt_dir;
         if (w_gnt_valid) begin
            r_ptr                   <= w_ptr_next;
            r_grant_id              <= w_gnt_idx;
            r_active_map[w_gnt_idx] <= w_gnt_dir;
         end
      end
   end

   assign change     = r_change;
   assign on_off     = r_on_off;
   assign grant_id   = r_grant_id;
   assign active_map = r_active_map;
   assign busy       = |r_pend;

endmodule

// File: tb/tb_iot_event_scheduler.sv
// tb/tb_iot_event_scheduler.sv - self-checking bench for iot_event_scheduler
module tb_iot_event_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] req_on = '0;
   logic       change;
   logic       on_off;
   logic [1:0] grant_id;
   logic [3:0] active_map;
   logic       busy;
   logic       drop;

   int checks = 0;
   int errors = 0;
   int mon_count = 0;

   typedef struct {
      logic       kind_drop;
      logic [1:0] id;
      logic       dir;
   } ev_t;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] req_on;
      logic       chg;
      logic       onoff;
      logic [1:0] gid;
      logic [3:0] amap;
      logic       busy;
   } vec_t;

   ev_t  sb[$];
   ev_t  mon_e;
   vec_t tbl[11];

   always #5 clk = ~clk;

   iot_event_scheduler #(.N_DEV(4), .ID_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_on     (req_on),
      .change     (change),
      .on_off     (on_off),
      .grant_id   (grant_id),
      .active_map (active_map),
      .busy       (busy),
      .drop       (drop)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic d, input logic [1:0] id, input logic dir);
      ev_t e;
      e.kind_drop = d;
      e.id        = id;
      e.dir       = dir;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] ro);
      req    = r;
      req_on = ro;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(4'b0000, 4'b0000);
      sb.delete();
      mon_count = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Scoreboard: every change/drop pulse must match the next expected event.
   always @(negedge clk) begin
      if (!rst && (change || drop)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got change=%0b drop=%0b id=%0d expected no event", change, drop, grant_id);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_kind", {30'b0, change, drop}, {30'b0, ~mon_e.kind_drop, mon_e.kind_drop});
            chk("sb_id", {30'b0, grant_id}, {30'b0, mon_e.id});
            if (change) begin
               chk("sb_dir", {31'b0, on_off}, {31'b0, mon_e.dir});
               mon_count += on_off ? 1 : -1;
            end
         end
      end
   end

   initial begin
      //          rst  req      req_on   chg on gid amap     busy
      tbl[0]  = '{1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
      tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
      tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0};
      tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0};
      tbl[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
      tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
      tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1};
      tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0011, 1'b1};
      tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0111, 1'b1};
      tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1111, 1'b0};
      tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b1111, 1'b0};

      push(1'b0, 2'd1, 1'b1);
      push(1'b0, 2'd0, 1'b1);
      push(1'b0, 2'd1, 1'b1);
      push(1'b0, 2'd2, 1'b1);
      push(1'b0, 2'd3, 1'b1);

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single event, reset between, then a four-device burst.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_change", i), {31'b0, change}, {31'b0, tbl[i].chg});
         chk($sformatf("v%0d_on_off", i), {31'b0, on_off}, {31'b0, tbl[i].onoff});
         chk($sformatf("v%0d_grant_id", i), {30'b0, grant_id}, {30'b0, tbl[i].gid});
         chk($sformatf("v%0d_active_map", i), {28'b0, active_map}, {28'b0, tbl[i].amap});
         chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].busy});
         chk($sformatf("v%0d_drop", i), {31'b0, drop}, 32'd0);
         rst = tbl[i].rst;
         drive(tbl[i].req, tbl[i].req_on);
         if (tbl[i].rst) mon_count = 0;
      end
      chk("burst_count", mon_count, 4);

      // Overwrite device 2 and re-arm device 0 at the edge that grants it.
      @(negedge clk);
      push(1'b0, 2'd0, 1'b0);
      push(1'b0, 2'd2, 1'b0);
      push(1'b0, 2'd0, 1'b1);
      drive(4'b0101, 4'b0100);
      @(negedge clk);
      drive(4'b0101, 4'b0001);
      @(negedge clk);
      drive(4'b0000, 4'b0000);
      chk("col_gid0", {30'b0, grant_id}, 32'd0);
      chk("col_amap0", {28'b0, active_map}, 32'b1110);
      chk("col_busy0", {31'b0, busy}, 32'd1);
      @(negedge clk);
      chk("col_gid1", {30'b0, grant_id}, 32'd2);
      chk("col_amap1", {28'b0, active_map}, 32'b1010);
      @(negedge clk);
      chk("col_gid2", {30'b0, grant_id}, 32'd0);
      chk("col_amap2", {28'b0, active_map}, 32'b1011);
      chk("col_busy2", {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk("col_idle", {31'b0, change}, 32'd0);
      chk("col_count", mon_count, 3);

      // Wrap-around: park ptr at 3 with devices 3 and 0 pending.
      push(1'b0, 2'd2, 1'b1);
      drive(4'b0100, 4'b0100);
      @(negedge clk);
      push(1'b0, 2'd3, 1'b0);
      push(1'b0, 2'd0, 1'b0);
      drive(4'b1001, 4'b0000);
      @(negedge clk);
      drive(4'b0000, 4'b0000);
      chk("wrap_gid2", {30'b0, grant_id}, 32'd2);
      chk("wrap_amap_a", {28'b0, active_map}, 32'b1111);
      @(negedge clk);
      chk("wrap_gid3", {30'b0, grant_id}, 32'd3);
      @(negedge clk);
      chk("wrap_gid0", {30'b0, grant_id}, 32'd0);
      chk("wrap_amap_b", {28'b0, active_map}, 32'b0110);
      chk("wrap_busy", {31'b0, busy}, 32'd0);
      push(1'b0, 2'd1, 1'b0);
      push(1'b0, 2'd0, 1'b1);
      drive(4'b0011, 4'b0001);
      @(negedge clk);
      drive(4'b0000, 4'b0000);
      @(negedge clk);
      chk("ptr1_first", {30'b0, grant_id}, 32'd1);
      @(negedge clk);
      chk("ptr1_second", {30'b0, grant_id}, 32'd0);
      chk("ptr1_amap", {28'b0, active_map}, 32'b0101);
      @(negedge clk);
      chk("wrap_count", mon_count, 2);

      // Device 3 turned on twice.
      do_reset();
      push(1'b0, 2'd3, 1'b1);
      drive(4'b1000, 4'b1000);
      @(negedge clk);
      drive(4'b0000, 4'b0000);
      @(negedge clk);
      chk("dup_first_change", {31'b0, change}, 32'd1);
      chk("dup_first_amap", {28'b0, active_map}, 32'b1000);
`ifdef SCHED_FILTER_EN
      push(1'b1, 2'd3, 1'b1);
`else
      push(1'b0, 2'd3, 1'b1);
`endif
      drive(4'b1000, 4'b1000);
      @(negedge clk);
      drive(4'b0000, 4'b0000);
      @(negedge clk);
`ifdef SCHED_FILTER_EN
      chk("dup_second_change", {31'b0, change}, 32'd0);
      chk("dup_second_drop", {31'b0, drop}, 32'd1);
`else
      chk("dup_second_change", {31'b0, change}, 32'd1);
      chk("dup_second_drop", {31'b0, drop}, 32'd0);
`endif
      chk("dup_amap", {28'b0, active_map}, 32'b1000);
      @(negedge clk);
      chk("dup_drop_clear", {31'b0, drop}, 32'd0);
`ifdef SCHED_FILTER_EN
      chk("dup_count", mon_count, 1);
`else
      chk("dup_count", mon_count, 2);
`endif

      // Asynchronous reset mid-cycle with three events pending.
      do_reset();
      drive(4'b0111, 4'b0111);
      @(negedge clk);
      drive(4'b0000, 4'b0000);
      chk("rst_pre_busy", {31'b0, busy}, 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_change", {31'b0, change}, 32'd0);
      chk("rst_on_off", {31'b0, on_off}, 32'd0);
      chk("rst_grant_id", {30'b0, grant_id}, 32'd0);
      chk("rst_active_map", {28'b0, active_map}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_drop", {31'b0, drop}, 32'd0);
      @(negedge clk);
      sb.delete();
      mon_count = 0;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_after_busy", {31'b0, busy}, 32'd0);
      chk("rst_after_change", {31'b0, change}, 32'd0);
      chk("rst_after_count", mon_count, 0);

      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
